exmem_memwb_regs: RTL and testbench
===================================

# exmem_memwb_regs

Pipeline register pair between Execute, Memory and Writeback in the 5-stage core. It captures EX results into the EX/MEM register, selects the writeback value into the MEM/WB register, and keeps a retired-instruction counter. It is the producer of `rd_m`, `rd_w`, `RegWrite_m` and `RegWrite_w`, which the forwarding logic compares against `rs1`/`rs2`. It also presents the forwarding data values and the load-in-MEM indication used by hazard logic.

## Interface
- `DATA_W`, 32: datapath width
- `REG_W`, 5: register index width
- `CNT_W`, 64: retire counter width

Ports:
- `clk`  in  1  — single clock, all state on rising edge
- `rst`  in  1  — reset, synchronous and active-high
- `stall_m`  in  1  — hold EX/MEM contents
- `flush_m`  in  1  — load a bubble into EX/MEM
- `valid_e`  in  1  — EX holds a real instruction
- `rd_e`  in  REG_W  — destination register from EX
- `RegWrite_e`, `MemRead_e`, `MemWrite_e`  in  1 each  — control from EX
- `alu_e`  in  DATA_W  — ALU result / memory address
- `store_e`  in  DATA_W  — store data (already forwarded)
- `rdata_m`  in  DATA_W  — data memory read data, combinational in MEM
- `valid_m`, `valid_w`  out  1  — stage occupancy
- `rd_m`, `rd_w`  out  REG_W  — destination indices
- `RegWrite_m`, `RegWrite_w`  out  1  — qualified write enables
- `MemRead_m`, `MemWrite_m`  out  1  — to data memory, gated by `valid_m`
- `alu_m`, `store_m`  out  DATA_W  — memory address / store data; `alu_m` is also MEM forward data
- `wbdata_w`  out  DATA_W  — writeback value; also WB forward data
- `load_in_m`  out  1  — `valid_m & MemRead_m`, for load-use stall detection
- `instret`  out  CNT_W  — count of retired instructions

## Operation
- EX/MEM register: on each edge, priority `rst` > `flush_m` > `stall_m` > load.
  - Load: capture all `*_e` fields, `valid_m <= valid_e`.
  - Stall: hold all fields.
  - Flush: `valid_m <= 0` and all control bits 0. Data fields are don't-care but are held.
- MEM/WB register: if `rst`, clear. Otherwise:
  - If `stall_m`: insert bubble (`valid_w <= 0`, `RegWrite_w <= 0`).
  - Else: `valid_w <= valid_m`, `rd_w <= rd_m`, `wbdata_w <= MemRead_m ? rdata_m : alu_m`, stored write enable `<= raw RegWrite_m`.
  - `flush_m` has no effect on MEM/WB.
- Qualification: `RegWrite_m = valid_m & RegWrite_m_raw & (rd_m != 0)`. `RegWrite_w` follows the same rule. Downstream comparators therefore never match x0 and never match a bubble.
- `MemRead_m`/`MemWrite_m` are 0 whenever `valid_m` = 0.
- `instret` increments by 1 on each edge where `valid_w` = 1. It wraps from all-ones to 0.

## Timing
- Reset values: every output is 0, including `instret`, `wbdata_w` and `alu_m`.
- Latency: EX inputs appear on `*_m` outputs one edge later and on `*_w` outputs two edges later, absent stall and flush.
- `rdata_m` is sampled on the same edge that moves MEM into WB. It must be valid combinationally while the instruction is in MEM.
- `instret` counts a retiring instruction on the edge after it is visible on `valid_w`. The counter lags WB by one cycle.
- Stall lasting N cycles: `*_m` is unchanged for N edges, WB receives N bubbles, and the instruction then advances.
- `stall_m` and `flush_m` asserted together: flush wins in EX/MEM, and WB still receives a bubble.
- `rst` asserted mid-stream clears both stages on that edge. No partial state survives.
- No combinational path from any input to any output except `rdata_m` → none. `wbdata_w` is registered, so no input-to-output path exists at all.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs → all outputs 0. `instret` stays 0 for 1 cycle after release when `valid_e` = 0.
- ALU flow: issue `rd_e`=5, `RegWrite_e`=1, `alu_e`=0x1234 → next cycle `rd_m`=5, `RegWrite_m`=1, `alu_m`=0x1234. Following cycle `rd_w`=5, `wbdata_w`=0x1234, and `instret`=1 one cycle after that.
- Load: `MemRead_e`=1, `rd_e`=7, `rdata_m`=0xDEADBEEF while in MEM → `load_in_m`=1 for 1 cycle, then `wbdata_w`=0xDEADBEEF.
- x0 write: `rd_e`=0, `RegWrite_e`=1 → `RegWrite_m`=0 and `RegWrite_w`=0. `valid_w`=1 and `instret` still increments.
- Stall/flush: hold `stall_m` 3 cycles with an instruction in MEM → `*_m` constant, `valid_w`=0 for 3 cycles, then the instruction retires. Assert `stall_m`+`flush_m` together → `valid_m`=0, `valid_w`=0.
- Counter wrap: with `CNT_W`=4, retire 17 instructions → `instret` = 1.

Source files
------------

// File: rtl/exmem_memwb_if.sv
// EX/MEM/WB pipeline register bundle: EX-side inputs, memory read data,
// and the MEM/WB outputs consumed by memory, forwarding and hazard logic.
interface exmem_memwb_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 64
);
    logic              stall_m;
    logic              flush_m;
    logic              valid_e;
    logic [REG_W-1:0]  rd_e;
    logic              RegWrite_e;
    logic              MemRead_e;
    logic              MemWrite_e;
    logic [DATA_W-1:0] alu_e;
    logic [DATA_W-1:0] store_e;
    logic [DATA_W-1:0] rdata_m;

    logic              valid_m;
    logic              valid_w;
    logic [REG_W-1:0]  rd_m;
    logic [REG_W-1:0]  rd_w;
    logic              RegWrite_m;
    logic              RegWrite_w;
    logic              MemRead_m;
    logic              MemWrite_m;
    logic [DATA_W-1:0] alu_m;
    logic [DATA_W-1:0] store_m;
    logic [DATA_W-1:0] wbdata_w;
    logic              load_in_m;
    logic [CNT_W-1:0]  instret;

    // Pipeline control / EX side drives the inputs and observes the outputs.
    modport master (
        output stall_m, flush_m, valid_e, rd_e, RegWrite_e, MemRead_e, MemWrite_e,
               alu_e, store_e, rdata_m,
        input  valid_m, valid_w, rd_m, rd_w, RegWrite_m, RegWrite_w, MemRead_m,
               MemWrite_m, alu_m, store_m, wbdata_w, load_in_m, instret
    );

    // The register pair itself.
    modport slave (
        input  stall_m, flush_m, valid_e, rd_e, RegWrite_e, MemRead_e, MemWrite_e,
               alu_e, store_e, rdata_m,
        output valid_m, valid_w, rd_m, rd_w, RegWrite_m, RegWrite_w, MemRead_m,
               MemWrite_m, alu_m, store_m, wbdata_w, load_in_m, instret
    );
endinterface

// File: rtl/exmem_memwb_regs.sv
// EX/MEM and MEM/WB pipeline registers with writeback-value selection and a
// retired-instruction counter. Write enables and memory strobes are
// qualified by stage occupancy so downstream comparators never match a
// bubble or x0.
module exmem_memwb_regs #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 64
) (
    input logic           clk,
    input logic           rst,
    exmem_memwb_if.slave  bus
);

    // EX/MEM stage state (p0)
    logic              r_vld_p0;
    logic [REG_W-1:0]  r_rd_p0;
    logic              r_rw_p0;
    logic              r_mr_p0;
    logic              r_mw_p0;
    logic [DATA_W-1:0] r_alu_p0;
    logic [DATA_W-1:0] r_store_p0;

    // MEM/WB stage state (p1)
    logic              r_vld_p1;
    logic [REG_W-1:0]  r_rd_p1;
    logic              r_rw_p1;
    logic [DATA_W-1:0] r_wb_p1;

    logic [CNT_W-1:0]  r_instret;

    logic              w_memread_p0;
    logic [DATA_W-1:0] w_wbsel_p0;

    assign w_memread_p0 = r_vld_p0 & r_mr_p0;
    assign w_wbsel_p0   = w_memread_p0 ? bus.rdata_m : r_alu_p0;

    // ---- EX -> MEM boundary ----
    // EX/MEM capture: reset clears everything, flush kills control but keeps
    // data, stall holds, otherwise load from EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0   <= 1'b0;
            r_rd_p0    <= '0;
            r_rw_p0    <= 1'b0;
            r_mr_p0    <= 1'b0;
            r_mw_p0    <= 1'b0;
            r_alu_p0   <= '0;
            r_store_p0 <= '0;
        end else if (bus.flush_m) begin
            r_vld_p0 <= 1'b0;
            r_rw_p0  <= 1'b0;
            r_mr_p0  <= 1'b0;
            r_mw_p0  <= 1'b0;
        end else if (!bus.stall_m) begin
            r_vld_p0   <= bus.valid_e;
            r_rd_p0    <= bus.rd_e;
            r_rw_p0    <= bus.RegWrite_e;
            r_mr_p0    <= bus.MemRead_e;
            r_mw_p0    <= bus.MemWrite_e;
            r_alu_p0   <= bus.alu_e;
            r_store_p0 <= bus.store_e;
        end
    end

    // ---- MEM -> WB boundary ----
    // MEM/WB capture: a stall in MEM sends a bubble to WB; flush is ignored
    // here so the instruction already in MEM still retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_rd_p1  <= '0;
            r_rw_p1  <= 1'b0;
            r_wb_p1  <= '0;
        end else if (bus.stall_m) begin
            r_vld_p1 <= 1'b0;
            r_rw_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= r_vld_p0;
            r_rd_p1  <= r_rd_p0;
            r_rw_p1  <= r_rw_p0;
            r_wb_p1  <= w_wbsel_p0;
        end
    end

    // Retire counter: counts each cycle WB holds a real instruction, so it
    // lags WB by one edge; wraps naturally at the counter width.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (r_vld_p1) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign bus.valid_m    = r_vld_p0;
    assign bus.rd_m       = r_rd_p0;
    assign bus.RegWrite_m = r_vld_p0 & r_rw_p0 & (r_rd_p0 != '0);
    assign bus.MemRead_m  = w_memread_p0;
    assign bus.MemWrite_m = r_vld_p0 & r_mw_p0;
    assign bus.alu_m      = r_alu_p0;
    assign bus.store_m    = r_store_p0;
    assign bus.load_in_m  = w_memread_p0;

    assign bus.valid_w    = r_vld_p1;
    assign bus.rd_w       = r_rd_p1;
    assign bus.RegWrite_w = r_vld_p1 & r_rw_p1 & (r_rd_p1 != '0);
    assign bus.wbdata_w   = r_wb_p1;
    assign bus.instret    = r_instret;

endmodule

// File: tb/tb_exmem_memwb_regs.sv
// Bench for exmem_memwb_regs: a stage-occupancy model plus a writeback
// scoreboard queue, driven by a linear sequence of directed steps.
module tb_exmem_memwb_regs;

    logic clk;
    logic rst;

    exmem_memwb_if #(.DATA_W(32), .REG_W(5), .CNT_W(64)) bus ();
    exmem_memwb_if #(.DATA_W(32), .REG_W(5), .CNT_W(4))  bus4 ();

    exmem_memwb_regs #(.DATA_W(32), .REG_W(5), .CNT_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exmem_memwb_regs #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple data memory: one magic address, everything else a fixed mangle.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hFFFF_0000);
    endfunction

    assign bus.rdata_m  = mem_rd(bus.alu_m);
    assign bus4.rdata_m = mem_rd(bus4.alu_m);

    assign bus4.stall_m    = bus.stall_m;
    assign bus4.flush_m    = bus.flush_m;
    assign bus4.valid_e    = bus.valid_e;
    assign bus4.rd_e       = bus.rd_e;
    assign bus4.RegWrite_e = bus.RegWrite_e;
    assign bus4.MemRead_e  = bus.MemRead_e;
    assign bus4.MemWrite_e = bus.MemWrite_e;
    assign bus4.alu_e      = bus.alu_e;
    assign bus4.store_e    = bus.store_e;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] alu;
        logic [31:0] st;
    } mrec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rwq;
    } wrec_t;

    mrec_t       m_st;
    logic        w_v;
    logic [63:0] exp_instret;
    wrec_t       sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_checks();
        wrec_t r;
        chk("valid_m", bus.valid_m, m_st.v);
        chk("rd_m", bus.rd_m, m_st.rd);
        chk("RegWrite_m", bus.RegWrite_m, m_st.v & m_st.rw & (m_st.rd != 5'd0));
        chk("MemRead_m", bus.MemRead_m, m_st.v & m_st.mr);
        chk("MemWrite_m", bus.MemWrite_m, m_st.v & m_st.mw);
        chk("load_in_m", bus.load_in_m, m_st.v & m_st.mr);
        chk("alu_m", bus.alu_m, m_st.alu);
        chk("store_m", bus.store_m, m_st.st);
        chk("valid_w", bus.valid_w, w_v);
        if (bus.valid_w === 1'b1) begin
            chk("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                r = sb_q.pop_front();
                chk("rd_w", bus.rd_w, r.rd);
                chk("wbdata_w", bus.wbdata_w, r.data);
                chk("RegWrite_w", bus.RegWrite_w, r.rwq);
            end
        end else begin
            chk("RegWrite_w_bubble", bus.RegWrite_w, 0);
        end
        chk("instret", bus.instret, exp_instret);
        chk("instret4", bus4.instret, {60'd0, exp_instret[3:0]});
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic step(input logic r, input logic v, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw,
                        input logic [31:0] alu, input logic [31:0] st,
                        input logic stall, input logic flush);
        mrec_t m_n;
        wrec_t wr;
        rst            = r;
        bus.valid_e    = v;
        bus.rd_e       = rd;
        bus.RegWrite_e = rw;
        bus.MemRead_e  = mr;
        bus.MemWrite_e = mw;
        bus.alu_e      = alu;
        bus.store_e    = st;
        bus.stall_m    = stall;
        bus.flush_m    = flush;
        @(posedge clk);
        if (r) begin
            m_st        = '0;
            w_v         = 1'b0;
            exp_instret = 64'd0;
            sb_q.delete();
        end else begin
            exp_instret = exp_instret + {63'd0, w_v};
            w_v = !stall && m_st.v;
            if (w_v) begin
                wr.rd   = m_st.rd;
                wr.data = m_st.mr ? mem_rd(m_st.alu) : m_st.alu;
                wr.rwq  = m_st.rw && (m_st.rd != 5'd0);
                sb_q.push_back(wr);
            end
            m_n = m_st;
            if (flush) begin
                m_n.v  = 1'b0;
                m_n.rw = 1'b0;
                m_n.mr = 1'b0;
                m_n.mw = 1'b0;
            end else if (!stall) begin
                m_n = '{v: v, rd: rd, rw: rw, mr: mr, mw: mw, alu: alu, st: st};
            end
            m_st = m_n;
        end
        @(negedge clk);
        do_checks();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        m_st        = '0;
        w_v         = 1'b0;
        exp_instret = 64'd0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("rst_wbdata_w", bus.wbdata_w, 0);
            chk("rst_rd_w", bus.rd_w, 0);
        end
        idle();
        chk("post_rst_instret", bus.instret, 0);

        // ALU flow
        step(1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 1'b0, 1'b0);
        chk("alu_rd_m", bus.rd_m, 5);
        chk("alu_RegWrite_m", bus.RegWrite_m, 1);
        chk("alu_alu_m", bus.alu_m, 32'h1234);
        idle();
        chk("alu_rd_w", bus.rd_w, 5);
        chk("alu_wbdata_w", bus.wbdata_w, 32'h1234);
        idle();
        chk("alu_instret", bus.instret, 1);

        // Load
        step(1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
        chk("ld_load_in_m", bus.load_in_m, 1);
        idle();
        chk("ld_load_in_m_gone", bus.load_in_m, 0);
        chk("ld_wbdata_w", bus.wbdata_w, 32'hDEAD_BEEF);
        idle();

        // x0 write
        step(1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 32'h77, 32'h99, 1'b0, 1'b0);
        chk("x0_RegWrite_m", bus.RegWrite_m, 0);
        chk("x0_MemWrite_m", bus.MemWrite_m, 1);
        idle();
        chk("x0_RegWrite_w", bus.RegWrite_w, 0);
        chk("x0_valid_w", bus.valid_w, 1);
        idle();
        chk("x0_instret", bus.instret, 3);

        // Stall three cycles with A in MEM, B waiting in EX
        step(1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 32'h55, 32'h66, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 32'hAA, 32'hBB, 1'b1, 1'b0);
            chk("stall_rd_m", bus.rd_m, 9);
            chk("stall_valid_w", bus.valid_w, 0);
        end
        step(1'b0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 32'hAA, 32'hBB, 1'b0, 1'b0);
        chk("stall_rd_w", bus.rd_w, 9);
        chk("stall_next_rd_m", bus.rd_m, 10);
        // Stall and flush together
        step(1'b0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 32'hCC, 32'hDD, 1'b1, 1'b1);
        chk("sf_valid_m", bus.valid_m, 0);
        chk("sf_valid_w", bus.valid_w, 0);
        idle();
        idle();

        // Random stream
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 32'h100 : $urandom, $urandom,
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 7) == 0));
        end

        // Mid-stream reset with a full pipeline
        step(1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h3, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 32'h6, 32'h0, 1'b0, 1'b0);
        chk("mrst_valid_m", bus.valid_m, 0);
        chk("mrst_valid_w", bus.valid_w, 0);
        chk("mrst_instret", bus.instret, 0);

        // Retire 17 instructions; the 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 5'(i + 1), 1'b1, 1'b0, 1'b0, 32'(i * 16), 32'(i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) idle();
        chk("wrap_instret4", bus4.instret, 1);
        chk("wrap_instret64", bus.instret, 17);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
